fetch_unit: RTL

//  Front-end counterpart of the Execute stage: consumes redirect_valid/redirect_pc/flush_ifid,

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit_ifid_pipe_reg.sv | 41 ++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: data width,
// fetch FSM state encoding and the NOP bubble encoding.
package fetch_unit_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0 -- the bubble presented to Decode whenever IF/ID is empty
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

endinterface

// File: rtl/fetch_unit_ifid_pipe_reg.sv
// IF/ID pipeline register: flush beats load beats hold; anything else empties
// the stage and parks the NOP bubble on the instruction bus.
module ifid_pipe_reg
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            load,
   input  logic            hold,
   input  logic [XLEN-1:0] load_pc,
   input  logic [XLEN-1:0] load_instr,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc_plus_4
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid     <= 1'b0;
         pc        <= '0;
         instr     <= NOP;
         pc_plus_4 <= XLEN'(4);
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP;
      end else if (load) begin
         valid     <= 1'b1;
         pc        <= load_pc;
         instr     <= load_instr;
         pc_plus_4 <= load_pc + XLEN'(4);
      end else if (!hold) begin
         valid <= 1'b0;
         instr <= NOP;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, absorbs EX
// redirects and feeds Decode through the IF/ID register.
module fetch_unit
   import fetch_unit_pkg::XLEN, fetch_unit_pkg::fetch_state_e, fetch_unit_pkg::word_align,
          fetch_unit_pkg::S_REQ, fetch_unit_pkg::S_WAIT, fetch_unit_pkg::S_HOLD,
          fetch_unit_pkg::S_DRAIN;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              flush_ifid,
   input  logic              id_stall,
   fetch_unit_if.master      imem,
   output logic              ifid_valid,
   output logic [XLEN-1:0]   ifid_pc,
   output logic [XLEN-1:0]   ifid_instr,
   output logic [XLEN-1:0]   ifid_pc_plus_4
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] buf_data_q, buf_data_d;
   logic [XLEN-1:0] redirect_tgt;
   logic [XLEN-1:0] load_instr;
   logic            hold;
   logic            req_ok;
   logic            ifid_load;

   assign hold         = ifid_valid & id_stall & ~flush_ifid;
   assign redirect_tgt = word_align(redirect_pc);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      buf_data_d = buf_data_q;
      req_ok     = 1'b0;
      ifid_load  = 1'b0;
      load_instr = imem.imem_rsp_data;
      case (state_q)
         S_REQ: begin
            req_ok = ~hold & ~redirect_valid;
            if (redirect_valid) begin
               pc_d = redirect_tgt;
            end else if (req_ok && imem.imem_req_ready) begin
               fetch_pc_d = pc_q;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.imem_rsp_valid) begin
               if (redirect_valid) begin
                  pc_d    = redirect_tgt;
                  state_d = S_REQ;
               end else if (!hold) begin
                  ifid_load = 1'b1;
                  pc_d      = fetch_pc_q + XLEN'(4);
                  state_d   = S_REQ;
               end else begin
                  buf_data_d = imem.imem_rsp_data;
                  state_d    = S_HOLD;
               end
            end else if (redirect_valid) begin
               // response still owed by memory; swallow it before refetching
               pc_d    = redirect_tgt;
               state_d = S_DRAIN;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               state_d = S_REQ;
            end else if (!hold) begin
               ifid_load  = 1'b1;
               load_instr = buf_data_q;
               pc_d       = fetch_pc_q + XLEN'(4);
               state_d    = S_REQ;
            end
         end
         S_DRAIN: begin
            if (redirect_valid) pc_d = redirect_tgt;
            if (imem.imem_rsp_valid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
   end

   assign imem.imem_req_valid = req_ok & ~rst;
   assign imem.imem_req_addr  = pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= word_align(RESET_PC);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
      fetch_pc_q <= fetch_pc_d;
      buf_data_q <= buf_data_d;
   end

   ifid_pipe_reg #(.NOP(NOP_INSTR)) u_ifid (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush_ifid),
      .load       (ifid_load),
      .hold       (hold),
      .load_pc    (fetch_pc_q),
      .load_instr (load_instr),
      .valid      (ifid_valid),
      .pc         (ifid_pc),
      .instr      (ifid_instr),
      .pc_plus_4  (ifid_pc_plus_4)
   );

   // memory never answers without an accepted request in flight
   rsp_only_when_outstanding: assert property (
      @(posedge clk) disable iff (rst) !(imem.imem_rsp_valid && state_q == S_REQ));

endmodule
